// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit: states, opcodes,
// datapath select values and the bundled control-line struct.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        StFetch   = 4'd0,
        StDecode  = 4'd1,
        StMemAdr  = 4'd2,
        StMemRd   = 4'd3,
        StMemWb   = 4'd4,
        StMemWr   = 4'd5,
        StExec    = 4'd6,
        StAluWb   = 4'd7,
        StBranch  = 4'd8,
        StJump    = 4'd9,
        StAddiEx  = 4'd10,
        StAddiWb  = 4'd11
    } state_e;

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpJ     = 6'b000010;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;

    localparam logic [1:0] AluOpAdd   = 2'b00;
    localparam logic [1:0] AluOpSub   = 2'b01;
    localparam logic [1:0] AluOpFunct = 2'b10;

    localparam logic [1:0] SrcBReg   = 2'b00;
    localparam logic [1:0] SrcBFour  = 2'b01;
    localparam logic [1:0] SrcBImm   = 2'b10;
    localparam logic [1:0] SrcBImmSh = 2'b11;

    localparam logic [1:0] PcSrcAlu    = 2'b00;
    localparam logic [1:0] PcSrcAluOut = 2'b01;
    localparam logic [1:0] PcSrcJump   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_write;
        logic       reg_dst;
        logic       alu_src_a;
        logic [1:0] pc_source;
        logic [1:0] alu_op;
        logic [1:0] alu_src_b;
    } ctrl_t;

endpackage

// File: rtl/mips_ctrl_decode.sv
// Combinational Moore output decode: state (plus MemReady in FETCH) to
// every datapath control line.
module mips_ctrl_decode
    import mips_ctrl_pkg::*;
(
    input  state_e state_i,
    input  logic   mem_ready_i,
    output ctrl_t  ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        case (state_i)
            StFetch: begin
                ctrl_o.mem_read  = 1'b1;
                ctrl_o.alu_src_b = SrcBFour;
                ctrl_o.ir_write  = mem_ready_i;
                ctrl_o.pc_write  = mem_ready_i;
            end
            StDecode: ctrl_o.alu_src_b = SrcBImmSh;
            StMemAdr, StAddiEx: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SrcBImm;
            end
            StMemRd: begin
                ctrl_o.mem_read = 1'b1;
                ctrl_o.i_or_d   = 1'b1;
            end
            StMemWb: begin
                ctrl_o.mem_to_reg = 1'b1;
                ctrl_o.reg_write  = 1'b1;
            end
            StMemWr: begin
                ctrl_o.mem_write = 1'b1;
                ctrl_o.i_or_d    = 1'b1;
            end
            StExec: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_op    = AluOpFunct;
            end
            StAluWb: begin
                ctrl_o.reg_dst   = 1'b1;
                ctrl_o.reg_write = 1'b1;
            end
            StBranch: begin
                ctrl_o.alu_src_a     = 1'b1;
                ctrl_o.alu_op        = AluOpSub;
                ctrl_o.pc_write_cond = 1'b1;
                ctrl_o.pc_source     = PcSrcAluOut;
            end
            StJump: begin
                ctrl_o.pc_write  = 1'b1;
                ctrl_o.pc_source = PcSrcJump;
            end
            StAddiWb: ctrl_o.reg_write = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS main control: state register, next-state logic, retired
// instruction counter and sticky illegal-opcode flag.
module mips_multicycle_control
    import mips_ctrl_pkg::*;
(
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic [5:0]  opcode_i,
    input  logic        zero_i,
    input  logic        mem_ready_i,
    output logic        pc_en_o,
    output logic        pc_write_o,
    output logic        pc_write_cond_o,
    output logic        i_or_d_o,
    output logic        mem_read_o,
    output logic        mem_write_o,
    output logic        ir_write_o,
    output logic        mem_to_reg_o,
    output logic        reg_write_o,
    output logic        reg_dst_o,
    output logic        alu_src_a_o,
    output logic [1:0]  pc_source_o,
    output logic [1:0]  alu_op_o,
    output logic [1:0]  alu_src_b_o,
    output logic [3:0]  state_o,
    output logic        illegal_op_o,
    output logic [31:0] instr_count_o
);

    state_e      state_q, state_d;
    logic [31:0] count_q, count_d;
    logic        illegal_q, illegal_d;
    ctrl_t       ctrl, ctrl_g;

    mips_ctrl_decode u_decode (
        .state_i     (state_q),
        .mem_ready_i (mem_ready_i),
        .ctrl_o      (ctrl)
    );

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        illegal_d = illegal_q;
        case (state_q)
            StFetch:  if (mem_ready_i) state_d = StDecode;
            StDecode: begin
                case (opcode_i)
                    OpLw, OpSw: state_d = StMemAdr;
                    OpRtype:    state_d = StExec;
                    OpBeq:      state_d = StBranch;
                    OpJ:        state_d = StJump;
                    OpAddi:     state_d = StAddiEx;
                    default: begin
                        state_d   = StFetch;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            StMemAdr: state_d = (opcode_i == OpLw) ? StMemRd : StMemWr;
            StMemRd:  if (mem_ready_i) state_d = StMemWb;
            StMemWr: begin
                if (mem_ready_i) begin
                    state_d = StFetch;
                    count_d = count_q + 32'd1;
                end
            end
            StExec:   state_d = StAluWb;
            StAddiEx: state_d = StAddiWb;
            StMemWb, StAluWb, StBranch, StJump, StAddiWb: begin
                state_d = StFetch;
                count_d = count_q + 32'd1;
            end
            default:  state_d = StFetch;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q   <= StFetch;
            count_q   <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            illegal_q <= illegal_d;
        end
    end

    // Reset silences every strobe so no register-file or memory write can leak out.
    assign ctrl_g = reset_i ? '0 : ctrl;

    assign pc_en_o         = ctrl_g.pc_write | (ctrl_g.pc_write_cond & zero_i);
    assign pc_write_o      = ctrl_g.pc_write;
    assign pc_write_cond_o = ctrl_g.pc_write_cond;
    assign i_or_d_o        = ctrl_g.i_or_d;
    assign mem_read_o      = ctrl_g.mem_read;
    assign mem_write_o     = ctrl_g.mem_write;
    assign ir_write_o      = ctrl_g.ir_write;
    assign mem_to_reg_o    = ctrl_g.mem_to_reg;
    assign reg_write_o     = ctrl_g.reg_write;
    assign reg_dst_o       = ctrl_g.reg_dst;
    assign alu_src_a_o     = ctrl_g.alu_src_a;
    assign pc_source_o     = ctrl_g.pc_source;
    assign alu_op_o        = ctrl_g.alu_op;
    assign alu_src_b_o     = ctrl_g.alu_src_b;
    assign state_o         = state_q;
    assign illegal_op_o    = illegal_q;
    assign instr_count_o   = count_q;

endmodule
